ifu: RTL and testbench
======================

Name: ifu

Overview:
- Instruction fetch unit. Sits directly upstream of the decode/execute core.
- Owns the fetch PC and issues word reads on a simple valid/ready memory request bus.
- Returns one instruction word at a time to the core on a valid/ready handshake.
- Accepts redirects (jal/jalr/branch targets) from the core and kills any fetch already in flight.
- Replaces direct combinational instruction reads, so memory latency may be one or more cycles.

Parameters:
- RESET_PC, 32'h80000000, first fetch address after reset.
- ADDR_W, 32, address/PC width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- redirect_valid  in  1  core requests fetch from redirect_pc
- redirect_pc  in  ADDR_W  new fetch target
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  word address, bits [1:0] always 0
- mem_resp_valid  in  1  read data valid (one cycle per accepted request)
- mem_resp_data  in  32  read data
- inst_valid  out  1  inst/inst_pc valid to core
- inst_ready  in  1  core consumes instruction
- inst  out  32  instruction word
- inst_pc  out  ADDR_W  PC of inst

Behaviour:
- Clocking/reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, fetch_pc=RESET_PC, kill=0, mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
- At most one outstanding memory request. The memory shares rst, so reset discards any outstanding request.
- mem_req_valid = (state==REQ). mem_req_addr = {fetch_pc[ADDR_W-1:2],2'b00}. No alignment trap is raised.
- mem_req_addr may change while valid=1 and ready=0; memory samples it only on the handshake cycle.
- inst_valid = (state==HOLD). inst and inst_pc are registers.
- States:
  - IDLE: unconditional -> REQ on the next edge. A redirect in IDLE loads fetch_pc.
  - REQ:
    - handshake (valid&ready) -> WAIT;
    - redirect without handshake -> fetch_pc<=redirect_pc, stay REQ;
    - redirect with handshake -> WAIT, kill<=1, fetch_pc<=redirect_pc.
  - WAIT:
    - resp_valid & !kill & !redirect_valid -> inst<=resp_data, inst_pc<=fetch_pc, -> HOLD;
    - resp_valid & (kill | redirect_valid) -> discard data, kill<=0, -> REQ; on redirect, fetch_pc<=redirect_pc;
    - redirect without resp -> kill<=1, fetch_pc<=redirect_pc, stay WAIT.
  - HOLD:
    - inst_ready & !redirect -> fetch_pc<=fetch_pc+4 (mod 2^ADDR_W), -> REQ;
    - redirect (with or without inst_ready) -> fetch_pc<=redirect_pc, -> REQ; redirect has priority and +4 is not applied;
    - neither -> hold inst/inst_pc stable.
- Timing: with a request handshake at cycle N and response at N+1, inst_valid rises at N+2 and the next mem_req_valid at N+3 if inst_ready=1 at N+2.
- After rst deasserts: mem_req_valid first high one cycle later (IDLE->REQ).
- mem_resp_valid outside WAIT is a protocol error: ignored, with a simulation assertion.
- Assertions:
  - mem_req_addr[1:0]==0;
  - inst/inst_pc stable while inst_valid & !inst_ready & !redirect_valid.
- PC wrap: 32'hFFFFFFFC+4 -> 32'h00000000, no flag.

Decomposition:
- Package ifu_pkg:
  - state enum IDLE=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3;
  - localparams PC_STEP=4 and default RESET_PC.
- Single module, no sub-module. State, fetch_pc, kill and output registers are inline. fetch_pc may use the team's existing parameterised register primitive with reset value RESET_PC.

Test Plan:
- Reset, then zero-latency memory (ready=1, resp next cycle), inst_ready=1 → mem_req_addr sequence 0x80000000, 0x80000004, 0x80000008; inst_pc matches; one instruction every 3 cycles.
- mem_req_ready held 0 for 4 cycles, then 1 → mem_req_valid stays 1 with addr 0x80000000 throughout; exactly one request issued.
- Response data 0x00100073 returned, inst_ready=0 for 5 cycles → inst_valid=1 and inst=0x00100073 stable for all 5; no new request until accept.
- Redirect to 0x80000100 while in WAIT (response 2 cycles later) → stale response dropped, inst_valid stays 0, next request addr 0x80000100, delivered inst_pc=0x80000100.
- Redirect to 0x80000040 in HOLD together with inst_ready=1 → next request addr 0x80000040, not old_pc+4.
- rst asserted for one cycle while in WAIT → state IDLE, inst_valid=0, mem_req_valid=0; the cycle after next, request addr 0x80000000.

Source files
------------

// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pkg
//  Description : Shared types and constants for the instruction fetch unit.
//                Holds the fetch FSM state encoding, the sequential PC step
//                and the default reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ifu
//  Description : Instruction fetch unit. Owns the fetch PC, issues one word
//                read at a time on a valid/ready request bus, and hands each
//                returned word to the core on a valid/ready handshake.
//                Redirects from the core replace the fetch PC and kill any
//                read already in flight.
//  Ports       : clk, rst                        - clock, sync active-high reset
//                redirect_valid/redirect_pc      - core fetch redirect
//                mem_req_valid/ready/addr        - memory read request
//                mem_resp_valid/data             - memory read response
//                inst_valid/ready, inst, inst_pc - instruction to the core
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc
);

    ifu_state_e        r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_kill;      // the outstanding read belongs to a stale PC
    logic [31:0]       r_inst;
    logic [ADDR_W-1:0] r_inst_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_kill     <= 1'b0;
            r_inst     <= 32'd0;
            r_inst_pc  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect_valid) r_fetch_pc <= redirect_pc;
                    r_state <= REQ;
                end
                REQ: begin
                    // The address may move while waiting for ready; memory
                    // only samples it on the handshake cycle.
                    if (redirect_valid) r_fetch_pc <= redirect_pc;
                    if (mem_req_ready) begin
                        r_state <= WAIT;
                        // Request was issued with the old PC: its data must die.
                        r_kill  <= redirect_valid;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (r_kill || redirect_valid) begin
                            r_kill  <= 1'b0;
                            r_state <= REQ;
                            if (redirect_valid) r_fetch_pc <= redirect_pc;
                        end else begin
                            r_inst    <= mem_resp_data;
                            r_inst_pc <= r_fetch_pc;
                            r_state   <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        r_kill     <= 1'b1;
                        r_fetch_pc <= redirect_pc;
                    end
                end
                HOLD: begin
                    // Redirect wins over sequential advance.
                    if (redirect_valid) begin
                        r_fetch_pc <= redirect_pc;
                        r_state    <= REQ;
                    end else if (inst_ready) begin
                        r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
                        r_state    <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req_valid = (r_state == REQ);
    assign mem_req_addr  = {r_fetch_pc[ADDR_W-1:2], 2'b00};
    assign inst_valid    = (r_state == HOLD);
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;

    // Request address is always word aligned.
    a_addr_aligned : assert property (@(posedge clk) disable iff (rst)
        mem_req_addr[1:0] == 2'b00);

    // An offered instruction must not change until taken or redirected.
    a_inst_stable : assert property (@(posedge clk) disable iff (rst)
        (inst_valid && !inst_ready && !redirect_valid) |=> ($stable(inst) && $stable(inst_pc)));

    // Memory may only respond while a read is outstanding.
    a_resp_in_wait : assert property (@(posedge clk) disable iff (rst)
        mem_resp_valid |-> (r_state == WAIT));

endmodule : ifu
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu
//  Description : Directed self-checking bench for the instruction fetch unit.
//                Memory responses are scripted cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifu #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(32'h8000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        inst_ready     = 1'b1;
        cyc();
        cyc();
        n_vec++;
        if ({mem_req_valid, inst_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_valids: got req=%b inst=%b expected 0 0", mem_req_valid, inst_valid);
        end
        n_vec++;
        if (inst !== 32'd0 || inst_pc !== 32'd0) begin
            n_err++;
            $display("FAIL reset_regs: got inst=%h pc=%h expected 0 0", inst, inst_pc);
        end
        rst = 1'b0;
        cyc();
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL first_req: got valid=%b addr=%h expected 1 80000000", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_zero_latency();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pc;
            logic [31:0] data;
            pc   = 32'h8000_0000 + 32'(4 * i);
            data = 32'hA000_0000 | 32'(i);
            n_vec++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== pc) begin
                n_err++;
                $display("FAIL zl_req%0d: got valid=%b addr=%h expected 1 %h", i, mem_req_valid, mem_req_addr, pc);
            end
            cyc();
            n_vec++;
            if ({mem_req_valid, inst_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL zl_wait%0d: got req=%b inst=%b expected 0 0", i, mem_req_valid, inst_valid);
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = data;
            cyc();
            mem_resp_valid = 1'b0;
            n_vec++;
            if (inst_valid !== 1'b1 || inst !== data || inst_pc !== pc) begin
                n_err++;
                $display("FAIL zl_inst%0d: got v=%b inst=%h pc=%h expected 1 %h %h", i, inst_valid, inst, inst_pc, data, pc);
            end
            cyc();
        end
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_000C) begin
            n_err++;
            $display("FAIL zl_next: got valid=%b addr=%h expected 1 8000000c", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_req_stall();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
                n_err++;
                $display("FAIL stall_req%0d: got valid=%b addr=%h expected 1 80000000", i, mem_req_valid, mem_req_addr);
            end
            if (i < 4) cyc();
        end
        mem_req_ready = 1'b1;
        cyc();
        cyc();
        n_vec++;
        if (mem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_single: got valid=%b expected 0", mem_req_valid);
        end
    endtask

    task automatic test_hold_stall();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0010_0073;
        inst_ready     = 1'b0;
        cyc();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (inst_valid !== 1'b1 || inst !== 32'h0010_0073 || inst_pc !== 32'h8000_0000 || mem_req_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hold%0d: got v=%b inst=%h pc=%h req=%b expected 1 00100073 80000000 0",
                         i, inst_valid, inst, inst_pc, mem_req_valid);
            end
            cyc();
        end
        inst_ready = 1'b1;
        cyc();
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_accept: got req=%b addr=%h iv=%b expected 1 80000004 0", mem_req_valid, mem_req_addr, inst_valid);
        end
    endtask

    task automatic test_redirect_wait();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        n_vec++;
        if ({mem_req_valid, inst_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL rw_wait: got req=%b inst=%b expected 0 0", mem_req_valid, inst_valid);
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        cyc();
        mem_resp_valid = 1'b0;
        n_vec++;
        if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100) begin
            n_err++;
            $display("FAIL rw_drop: got iv=%b req=%b addr=%h expected 0 1 80000100", inst_valid, mem_req_valid, mem_req_addr);
        end
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1234_5678;
        cyc();
        mem_resp_valid = 1'b0;
        n_vec++;
        if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || inst_pc !== 32'h8000_0100) begin
            n_err++;
            $display("FAIL rw_inst: got v=%b inst=%h pc=%h expected 1 12345678 80000100", inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_redirect_hold();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0040;
        cyc();
        redirect_valid = 1'b0;
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0040 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rh_req: got req=%b addr=%h iv=%b expected 1 80000040 0", mem_req_valid, mem_req_addr, inst_valid);
        end
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0013;
        cyc();
        mem_resp_valid = 1'b0;
        n_vec++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0040) begin
            n_err++;
            $display("FAIL rh_inst: got v=%b pc=%h expected 1 80000040", inst_valid, inst_pc);
        end
        cyc();
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0044) begin
            n_err++;
            $display("FAIL rh_next: got req=%b addr=%h expected 1 80000044", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_pc_wrap();
        // Redirect on the same cycle the request handshakes: its data is stale.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0BAD_F00D;
        cyc();
        mem_resp_valid = 1'b0;
        n_vec++;
        if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_kill: got iv=%b req=%b addr=%h expected 0 1 fffffffc", inst_valid, mem_req_valid, mem_req_addr);
        end
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0073;
        cyc();
        mem_resp_valid = 1'b0;
        n_vec++;
        if (inst_valid !== 1'b1 || inst !== 32'h0000_0073 || inst_pc !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_inst: got v=%b inst=%h pc=%h expected 1 00000073 fffffffc", inst_valid, inst, inst_pc);
        end
        cyc();
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL wrap_next: got req=%b addr=%h expected 1 00000000", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        cyc();
        rst = 1'b1;
        cyc();
        n_vec++;
        if ({mem_req_valid, inst_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_wait: got req=%b inst=%b expected 0 0", mem_req_valid, inst_valid);
        end
        rst = 1'b0;
        cyc();
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL rst_req: got req=%b addr=%h expected 1 80000000", mem_req_valid, mem_req_addr);
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_req_stall();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_pc_wrap();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion within 100000 ns");
        $fatal(1);
    end

endmodule : tb_ifu
`default_nettype wire
